// File: rtl/uart_tx_ctrl.sv
// Sequencing controller for the UART transmitter output mux. It steps one frame
// START -> DATA (LSB first) -> optional PARITY -> STOP, advancing one bit per CLK.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STATEWIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [STATEWIDTH-1:0] mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  Busy
);

  localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Encodings double as the TX mux select codes.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                  state_q;
  logic [STATEWIDTH-1:0]   mux_sel_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    busy_q;

  function automatic logic [STATEWIDTH-1:0] sel_of(input state_e s);
    return STATEWIDTH'(s);
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      mux_sel_q <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DATA_VALID) begin
            shift_q   <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
            cnt_q     <= '0;
            state_q   <= S_START;
            mux_sel_q <= sel_of(S_START);
            busy_q    <= 1'b1;
          end
        end

        S_START: begin
          state_q   <= S_DATA;
          mux_sel_q <= sel_of(S_DATA);
        end

        S_DATA: begin
          // The shifter empties as the payload goes out, so ser_data idles at 0.
          shift_q <= shift_q >> 1;
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            if (par_en_q) begin
              state_q   <= S_PARITY;
              mux_sel_q <= sel_of(S_PARITY);
            end else begin
              state_q   <= S_STOP;
              mux_sel_q <= sel_of(S_STOP);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          state_q   <= S_STOP;
          mux_sel_q <= sel_of(S_STOP);
        end

        S_STOP: begin
          state_q   <= S_IDLE;
          mux_sel_q <= sel_of(S_IDLE);
          busy_q    <= 1'b0;
        end

        default: begin
          state_q   <= S_IDLE;
          mux_sel_q <= sel_of(S_IDLE);
          cnt_q     <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mux_sel  = mux_sel_q;
  assign ser_data = shift_q[0];
  assign par_bit  = par_bit_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-position model predicts every output each cycle,
// directed frames pin the model against hand-derived sequences, then random traffic.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [2:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         Busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  uart_tx_ctrl #(.DATA_WIDTH(W), .STATEWIDTH(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: position inside the current frame (-1 = idle), plus the latched frame config.
  int         m_pos  = -1;
  logic [W-1:0] m_data = '0;
  int         m_pe   = 0;
  logic       m_par  = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_pos  <= -1;
      m_data <= '0;
      m_pe   <= 0;
      m_par  <= 1'b0;
    end else if (m_pos < 0) begin
      if (DATA_VALID) begin
        m_pos  <= 0;
        m_data <= P_DATA;
        m_pe   <= PAR_EN ? 1 : 0;
        m_par  <= (($countones(P_DATA) % 2) == 1) ^ PAR_TYP;
      end
    end else if (m_pos == 1 + W + m_pe) begin
      m_pos <= -1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic int exp_mux();
    if (m_pos < 0)                      return 0;
    if (m_pos == 0)                     return 1;
    if (m_pos <= W)                     return 2;
    if (m_pos == W + 1 && m_pe == 1)    return 3;
    return 4;
  endfunction

  function automatic int exp_ser();
    if (m_pos == 0)               return int'(m_data[0]);
    if (m_pos >= 1 && m_pos <= W) return int'(m_data[m_pos-1]);
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_mux_sel", int'(mux_sel), exp_mux());
      chk("model_ser_data", int'(ser_data), exp_ser());
      chk("model_par_bit", int'(par_bit), int'(m_par));
      chk("model_busy", int'(Busy), (m_pos >= 0) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic send_one(input logic [W-1:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
  endtask

  int lit_mux [12];
  int lit_ser [8];

  // Sends one frame and compares each cycle with the hand-written sequences in lit_*.
  task automatic frame_literal(input string tag, input logic [W-1:0] d, input logic pe,
                               input logic pt, input int nexp, input int par_exp,
                               input int busy_exp);
    int busy_cnt = 0;
    int bit_i    = 0;
    send_one(d, pe, pt);
    for (int k = 0; k < nexp; k++) begin
      #1;
      chk({tag, "_mux"}, int'(mux_sel), lit_mux[k]);
      if (lit_mux[k] == 2 && bit_i < 8) begin
        chk({tag, "_ser"}, int'(ser_data), lit_ser[bit_i]);
        bit_i++;
      end
      busy_cnt += int'(Busy);
      P_DATA  = W'($urandom);
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
      step();
    end
    chk({tag, "_par"}, int'(par_bit), par_exp);
    chk({tag, "_busy_cycles"}, busy_cnt, busy_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    logic [7:0] d3c;
    RST        = 1'b0;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    d3c        = 8'h3C;

    step(); step(); step();
    #1;
    chk("reset_mux", int'(mux_sel), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_ser", int'(ser_data), 0);
    chk("reset_par", int'(par_bit), 0);
    step();
    RST    = 1'b1;
    cmp_en = 1'b1;
    step();

    // A5 with even parity, then odd parity
    lit_mux = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 4, 0};
    lit_ser = '{1, 0, 1, 0, 0, 1, 0, 1};
    frame_literal("t1", 8'hA5, 1'b1, 1'b0, 12, 0, 11);
    frame_literal("t2", 8'hA5, 1'b1, 1'b1, 12, 1, 11);

    // FF without parity slot
    lit_mux = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 4, 0, 0};
    lit_ser = '{1, 1, 1, 1, 1, 1, 1, 1};
    frame_literal("t3", 8'hFF, 1'b0, 1'b0, 11, 0, 10);

    // DATA_VALID held high, payload changed mid-frame
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    step(); step(); step();
    P_DATA = 8'h3C;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (mux_sel == 3'd4) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t4_reached_stop", found, 1);
    step();
    #1;
    chk("t4_gap_idle", int'(mux_sel), 0);
    step();
    #1;
    chk("t4_restart", int'(mux_sel), 1);
    for (int k = 0; k < 8; k++) begin
      step();
      #1;
      chk("t4_ser_3c", int'(ser_data), int'(d3c[k]));
    end
    DATA_VALID = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      if (!Busy) begin
        found = 1;
        break;
      end
    end
    chk("t4_drained", found, 1);
    step();

    // Reset during DATA bit 3
    send_one(8'hFF, 1'b1, 1'b1);
    step(); step(); step(); step();
    #1;
    chk("t5_pre_mux", int'(mux_sel), 2);
    RST = 1'b0;
    #1;
    chk("t5_rst_mux", int'(mux_sel), 0);
    chk("t5_rst_busy", int'(Busy), 0);
    chk("t5_rst_ser", int'(ser_data), 0);
    chk("t5_rst_par", int'(par_bit), 0);
    step();
    RST = 1'b1;
    step();
    send_one(8'h5A, 1'b0, 1'b1);
    #1;
    chk("t5_clean_start", int'(mux_sel), 1);
    for (int k = 0; k < 12; k++) step();

    // DATA_VALID pulsed during PARITY and STOP
    send_one(8'h96, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) step();
    #1;
    chk("t6_parity", int'(mux_sel), 3);
    DATA_VALID = 1'b1;
    step();
    #1;
    chk("t6_stop", int'(mux_sel), 4);
    step();
    DATA_VALID = 1'b0;
    #1;
    chk("t6_idle_mux", int'(mux_sel), 0);
    chk("t6_idle_busy", int'(Busy), 0);
    step();
    #1;
    chk("t6_no_restart", int'(mux_sel), 0);

    // Random traffic with occasional short async reset pulses
    for (int k = 0; k < 500; k++) begin
      DATA_VALID = ($urandom_range(3) == 0);
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      if ($urandom_range(96) == 0) begin
        RST = 1'b0;
        #1;
        RST = 1'b1;
      end
      step();
    end
    DATA_VALID = 1'b0;
    for (int k = 0; k < 14; k++) step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
